redmule_job_dispatcher: RTL

Host-side job queue and issuer that drives the RedMulE controller's configuration/start handshake from the initiator side. Buffers up to `QueueDepth` job descriptors and presents the head descriptor as the engine configuration. Pulses start, waits for configuration acceptance and then end-of-job, and returns a tagged completion record to the host. Sits between the cluster-side register/queue interface and the accelerator controller.

---
 rtl/redmule_job_dispatcher.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/redmule_job_dispatcher.sv
// Host-side job queue and start/config handshake issuer for the RedMulE controller.
// Optional watchdog: define REDMULE_DISPATCH_WATCHDOG_EN to abort jobs after TimeoutCycles.
module redmule_job_dispatcher #(
    parameter int unsigned QueueDepth    = 4,
    parameter int unsigned DescWidth     = 256,
    parameter int unsigned IdWidth       = 8,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    input  logic [DescWidth-1:0]               job_desc_i,
    input  logic [IdWidth-1:0]                 job_id_i,
    output logic [DescWidth-1:0]               config_o,
    output logic                               start_cfg_o,
    input  logic                               cfg_complete_i,
    input  logic                               busy_i,
    input  logic                               evt_i,
    output logic                               done_valid_o,
    input  logic                               done_ready_i,
    output logic [IdWidth-1:0]                 done_id_o,
    output logic                               done_err_o,
    output logic [$clog2(QueueDepth+1)-1:0]    pending_o
);

    localparam int unsigned PtrWidth = $clog2(QueueDepth);
    localparam int unsigned CntWidth = $clog2(QueueDepth + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIssue   = 3'd1;
    localparam logic [2:0] StWaitCfg = 3'd2;
    localparam logic [2:0] StRunning = 3'd3;
    localparam logic [2:0] StReport  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic [IdWidth-1:0]   done_id_q, done_id_d;
    logic                 done_err_q, done_err_d;
    logic                 push;
    logic                 pop;
    logic                 timeout;

    logic [DescWidth-1:0] desc_mem_q [QueueDepth];
    logic [IdWidth-1:0]   id_mem_q   [QueueDepth];

    assign job_ready_o = (count_q != CntWidth'(QueueDepth));
    assign push        = job_valid_i & job_ready_o & ~clear_i;

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        done_id_d  = done_id_q;
        done_err_d = done_err_q;
        case (state_q)
            StIdle: begin
                if ((count_q != '0) && !busy_i) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitCfg;
            end
            StWaitCfg: begin
                if (timeout) begin
                    pop        = 1'b1;
                    state_d    = StReport;
                    done_id_d  = id_mem_q[rd_ptr_q];
                    done_err_d = 1'b1;
                end else if (cfg_complete_i) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                // End-of-job beats a watchdog expiry in the same cycle.
                if (evt_i || timeout) begin
                    pop        = 1'b1;
                    state_d    = StReport;
                    done_id_d  = id_mem_q[rd_ptr_q];
                    done_err_d = ~evt_i;
                end
            end
            StReport: begin
                if (done_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (clear_i) begin
            state_d    = StIdle;
            pop        = 1'b0;
            done_id_d  = '0;
            done_err_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrWidth'(push);
        rd_ptr_d = rd_ptr_q + PtrWidth'(pop);
        count_d  = count_q + CntWidth'(push) - CntWidth'(pop);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_id_q  <= '0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_id_q  <= done_id_d;
            done_err_q <= done_err_d;
        end
    end

    // NOTE: the descriptor storage is not reset; count_q gates every read, so stale slots never escape.
    always_ff @(posedge clk_i) begin
        if (push) begin
            desc_mem_q[wr_ptr_q] <= job_desc_i;
            id_mem_q[wr_ptr_q]   <= job_id_i;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef REDMULE_DISPATCH_WATCHDOG_EN
    logic [31:0] wdt_q, wdt_d;
    logic        wdt_active;

    assign wdt_active = (state_q == StWaitCfg) || (state_q == StRunning);
    // Expire on the cycle whose increment would reach the limit, so REPORT lands TimeoutCycles after WAIT_CFG entry.
    assign timeout    = wdt_active && ((wdt_q + 32'd1) == 32'(TimeoutCycles));

    always_comb begin
        wdt_d = wdt_q;
        if (state_q == StIssue) begin
            wdt_d = '0;
        end else if (wdt_active) begin
            wdt_d = wdt_q + 32'd1;
        end
        if (clear_i) begin
            wdt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TimeoutCycles;
    assign timeout               = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign config_o     = (count_q != '0) ? desc_mem_q[rd_ptr_q] : '0;
    assign start_cfg_o  = (state_q == StIssue);
    assign done_valid_o = (state_q == StReport);
    assign done_id_o    = done_id_q;
    assign done_err_o   = done_err_q;
    assign pending_o    = count_q;

endmodule
